seq_mux: RTL and testbench
==========================

# seq_mux

Registered, parametrised N-to-1 selector with valid/ready output handshake and an auto-sweep mode that streams every input in index order. It is the next-generation channel selector for the FIR datapath: it feeds coefficients or tap samples into the configurable pipelined multiplier, either on demand (direct select) or as a time-multiplexed burst (sweep).

## Interface
- WIDTH, 32, data width of each input and of the output
- INPUT_NUM, 5, number of inputs (≥2)
- SEL_W, $clog2(INPUT_NUM), select/index width (derived, not overridden)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- inputs  in  INPUT_NUM x WIDTH  unpacked array [0:INPUT_NUM-1] of data inputs
- mode  in  1  0 = direct select, 1 = sweep
- select  in  SEL_W  requested index (direct mode)
- sel_valid  in  1  direct-mode request strobe
- start  in  1  sweep start strobe
- out_ready  in  1  downstream can accept
- out_put  out  WIDTH  registered selected data
- out_valid  out  1  out_put holds an unconsumed beat
- out_index  out  SEL_W  index that produced out_put
- last  out  1  beat is final of a sweep
- busy  out  1  sweep in progress
- err  out  1  one-cycle pulse: out-of-range select accepted

## Operation
- Output stage: single register; load = !out_valid || out_ready. Beat consumed when out_valid && out_ready.
- While out_valid && !out_ready: out_put, out_index, last held stable; no new request accepted.
- FSM states IDLE, SWEEP; index counter idx (SEL_W bits).
- IDLE, mode=0: sel_valid && load → register inputs[select], out_index=select, last=0, out_valid=1.
- IDLE, mode=1: start → SWEEP, idx=0, busy=1. sel_valid ignored in mode 1.
- IDLE, no request && load → out_valid=0.
- SWEEP: each cycle with load, register inputs[idx], out_index=idx, out_valid=1; idx increments. Beat with idx=INPUT_NUM-1 sets last=1, FSM → IDLE, busy=0 same edge.
- SWEEP ignores start, sel_valid, select, mode; mode change takes effect only in IDLE.
- Data sampled from inputs at the loading edge; later input changes do not affect a held beat.
- Out-of-range select (select ≥ INPUT_NUM): see Configuration.

## Timing
- Reset: out_put=0, out_valid=0, out_index=0, last=0, busy=0, err=0, FSM=IDLE, idx=0.
- Reset mid-sweep or mid-stall: all above values next edge; pending beat discarded.
- Latency: accepted request/sweep step → out_valid the following cycle.
- Throughput: 1 beat/cycle with out_ready held high; sweep of INPUT_NUM beats spans INPUT_NUM cycles, first beat one cycle after start.
- busy rises the cycle after start, falls on the edge that loads the last beat.
- start and last beat in same cycle: start ignored (FSM still SWEEP when sampled).
- Back-to-back sweep: start sampled in the cycle busy=0 is honoured.
- err is high exactly one cycle, coincident with the errant beat's first out_valid cycle.

## Configuration
- SEQ_MUX_SAT_SEL_EN defined: out-of-range select saturates to INPUT_NUM-1; out_put=inputs[INPUT_NUM-1], out_index=INPUT_NUM-1, err pulses.
- Undefined: out-of-range select yields out_put=0, out_index=select, err pulses.
- Irrelevant when INPUT_NUM is a power of two (no out-of-range codes); err stays 0.

## Test plan
- WIDTH=32, INPUT_NUM=5, inputs[i]=i+100, out_ready=1: direct select 0..4 one per cycle → out_put 100..104 each one cycle later, out_valid continuous, last=0, err=0.
- select=6, sel_valid=1: without macro → out_put=0, out_index=6, err=1 one cycle; with SEQ_MUX_SAT_SEL_EN → out_put=104, out_index=4, err=1.
- mode=1, start pulse, out_ready=1 → beats 100..104 on five consecutive cycles, last=1 only on 104, busy high exactly those five load edges.
- Sweep with out_ready=0 on beat index 2 for 3 cycles → out_put=102, out_index=2 held stable 4 cycles; then 103, 104 follow; no beat lost or duplicated.
- start pulsed again mid-sweep and on last-beat cycle → ignored; start on first cycle busy=0 → new sweep begins at 100.
- rst asserted during sweep at index 3 → next cycle out_valid=0, busy=0, out_put=0, last=0; subsequent start restarts at index 0.

Source files
------------

// File: rtl/seq_mux_if.sv
// Output stream of seq_mux: registered data beat plus its source index and
// end-of-sweep marker, moved with a valid/ready handshake.
interface seq_mux_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
);
  logic [WIDTH-1:0] out_put;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_index;
  logic             last;

  modport master (
    output out_put,
    output out_valid,
    output out_index,
    output last,
    input  out_ready
  );

  modport slave (
    input  out_put,
    input  out_valid,
    input  out_index,
    input  last,
    output out_ready
  );
endinterface

// File: rtl/seq_mux.sv
// Registered N-to-1 selector with direct-select and auto-sweep modes.
// Optional macro SEQ_MUX_SAT_SEL_EN: out-of-range select saturates to the top input.
module seq_mux #(
  parameter  int WIDTH     = 32,
  parameter  int INPUT_NUM = 5,
  localparam int SEL_W     = $clog2(INPUT_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inputs [0:INPUT_NUM-1],
  input  logic             mode,
  input  logic [SEL_W-1:0] select,
  input  logic             sel_valid,
  input  logic             start,
  seq_mux_if.master        out_if,
  output logic             busy,
  output logic             err,
  output logic             fsm_state
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(INPUT_NUM - 1);
  localparam logic [SEL_W:0]   LIMIT    = (SEL_W + 1)'(INPUT_NUM);

  state_t           state, next_state;
  logic [SEL_W-1:0] idx, next_idx;
  logic [WIDTH-1:0] next_put;
  logic             next_valid;
  logic [SEL_W-1:0] next_index;
  logic             next_last;
  logic             next_err;

  logic             load;
  logic             oor;
  logic [WIDTH-1:0] dir_data;
  logic [SEL_W-1:0] dir_index;
  logic [WIDTH-1:0] sweep_data;

  // Handshake: a beat is transferred when out_valid && out_ready; the output
  // register only reloads when it is empty or being drained (load), so a
  // stalled beat keeps data, index and last stable.
  assign load      = !out_if.out_valid || out_if.out_ready;
  assign oor       = ({1'b0, select} >= LIMIT);
  assign busy      = (state == SWEEP);
  assign fsm_state = state;

  always_comb begin
    dir_data   = '0;
    sweep_data = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      if (select == SEL_W'(i)) dir_data = inputs[i];
      if (idx == SEL_W'(i))    sweep_data = inputs[i];
    end
    dir_index = select;
`ifdef SEQ_MUX_SAT_SEL_EN
    if (oor) begin
      dir_data  = inputs[INPUT_NUM-1];
      dir_index = LAST_IDX;
    end
`else
    // No input matches an out-of-range code, so dir_data is already zero.
`endif
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_put   = out_if.out_put;
    next_valid = out_if.out_valid;
    next_index = out_if.out_index;
    next_last  = out_if.last;
    next_err   = 1'b0;
    case (state)
      IDLE: begin
        if (mode) begin
          if (start) begin
            next_state = SWEEP;
            next_idx   = '0;
          end
          if (load) begin
            next_valid = 1'b0;
            next_last  = 1'b0;
          end
        end else if (load) begin
          if (sel_valid) begin
            next_put   = dir_data;
            next_index = dir_index;
            next_last  = 1'b0;
            next_valid = 1'b1;
            next_err   = oor;
          end else begin
            next_valid = 1'b0;
            next_last  = 1'b0;
          end
        end
      end
      SWEEP: begin
        if (load) begin
          next_put   = sweep_data;
          next_index = idx;
          next_valid = 1'b1;
          next_last  = (idx == LAST_IDX);
          if (idx == LAST_IDX) begin
            next_state = IDLE;
            next_idx   = '0;
          end else begin
            next_idx = idx + SEL_W'(1);
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      out_if.out_put   <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_index <= '0;
      out_if.last      <= 1'b0;
      err              <= 1'b0;
    end else begin
      state            <= next_state;
      idx              <= next_idx;
      out_if.out_put   <= next_put;
      out_if.out_valid <= next_valid;
      out_if.out_index <= next_index;
      out_if.last      <= next_last;
      err              <= next_err;
    end
  end

endmodule

// File: tb/tb_seq_mux.sv
// Directed self-checking bench for seq_mux (WIDTH=32, INPUT_NUM=5, inputs[i]=i+100).
module tb_seq_mux;
  localparam int WIDTH     = 32;
  localparam int INPUT_NUM = 5;
  localparam int SEL_W     = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] inputs [0:INPUT_NUM-1];
  logic             mode;
  logic [SEL_W-1:0] select;
  logic             sel_valid;
  logic             start;
  logic             busy;
  logic             err;
  logic             fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mux_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  seq_mux #(.WIDTH(WIDTH), .INPUT_NUM(INPUT_NUM)) dut (
    .clk       (clk),
    .rst       (rst),
    .inputs    (inputs),
    .mode      (mode),
    .select    (select),
    .sel_valid (sel_valid),
    .start     (start),
    .out_if    (bus),
    .busy      (busy),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one edge; outputs are sampled 1ns after it, inputs driven then too
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input int data, input int index,
                            input bit lst, input bit bsy);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"},  64'(bus.out_put),   64'(data));
    check({tag, "_index"}, 64'(bus.out_index), 64'(index));
    check({tag, "_last"},  64'(bus.last),      64'(lst));
    check({tag, "_busy"},  64'(busy),          64'(bsy));
  endtask

  initial begin
    for (int i = 0; i < INPUT_NUM; i++) inputs[i] = 32'(i + 100);
    rst = 1'b1; mode = 1'b0; select = '0; sel_valid = 1'b0; start = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data",  64'(bus.out_put),   64'd0);
    check("rst_index", 64'(bus.out_index), 64'd0);
    check("rst_last",  64'(bus.last),      64'd0);
    check("rst_busy",  64'(busy),          64'd0);
    check("rst_err",   64'(err),           64'd0);
    rst = 1'b0;

    // direct select 0..4, one per cycle
    for (int i = 0; i < INPUT_NUM; i++) begin
      select = SEL_W'(i); sel_valid = 1'b1;
      step();
      check_beat("dir", 100 + i, i, 1'b0, 1'b0);
      check("dir_err", 64'(err), 64'd0);
    end
    sel_valid = 1'b0;
    step();
    check("dir_idle_valid", 64'(bus.out_valid), 64'd0);

    // out-of-range select
    select = 3'd6; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
`ifdef SEQ_MUX_SAT_SEL_EN
    check_beat("oor", 104, 4, 1'b0, 1'b0);
`else
    check_beat("oor", 0, 6, 1'b0, 1'b0);
`endif
    check("oor_err", 64'(err), 64'd1);
    step();
    check("oor_err_clear", 64'(err), 64'd0);
    check("oor_idle_valid", 64'(bus.out_valid), 64'd0);

    // sweep with mid-sweep and last-beat start pulses
    mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("sw_busy_rise", 64'(busy), 64'd1);
    check("sw_pre_valid", 64'(bus.out_valid), 64'd0);
    for (int k = 0; k < INPUT_NUM; k++) begin
      start = (k == 1) || (k == 4);
      step();
      start = 1'b0;
      check_beat("sw", 100 + k, k, k == 4, k < 4);
    end
    // first cycle with busy low: start is honoured
    start = 1'b1;
    step();
    start = 1'b0;
    check("sw2_busy", 64'(busy), 64'd1);
    check("sw2_gap_valid", 64'(bus.out_valid), 64'd0);
    for (int k = 0; k < INPUT_NUM; k++) begin
      step();
      check_beat("sw2", 100 + k, k, k == 4, k < 4);
    end
    step();
    check("sw2_end_valid", 64'(bus.out_valid), 64'd0);
    check("sw2_end_busy",  64'(busy), 64'd0);

    // sweep stalled on index 2 for three cycles, input changed under the stall
    start = 1'b1;
    step();
    start = 1'b0;
    step(); check_beat("st", 100, 0, 1'b0, 1'b1);
    step(); check_beat("st", 101, 1, 1'b0, 1'b1);
    step(); check_beat("st", 102, 2, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    inputs[2] = 32'd999;
    for (int k = 0; k < 3; k++) begin
      step();
      check_beat("st_hold", 102, 2, 1'b0, 1'b1);
    end
    bus.out_ready = 1'b1;
    inputs[2] = 32'd102;
    step(); check_beat("st", 103, 3, 1'b0, 1'b1);
    step(); check_beat("st", 104, 4, 1'b1, 1'b0);
    step();
    check("st_end_valid", 64'(bus.out_valid), 64'd0);

    // reset while sweep output sits on index 3
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check_beat("rs_pre", 103, 3, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs_valid", 64'(bus.out_valid), 64'd0);
    check("rs_busy",  64'(busy),          64'd0);
    check("rs_data",  64'(bus.out_put),   64'd0);
    check("rs_last",  64'(bus.last),      64'd0);
    check("rs_index", 64'(bus.out_index), 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < INPUT_NUM; k++) begin
      step();
      check_beat("rs_sw", 100 + k, k, k == 4, k < 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
